mips_mc_ctrl: RTL and testbench

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/mips_mc_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences fetch, decode,
// execute, memory and write-back states and decodes the datapath controls.
// Ports:
//   clk, rst_n (async active-low) -- clock and reset
//   opcode, funct                 -- instruction fields, stable after DECODE
//   mem_ready                     -- memory finishes the current access
//   PCWrite..halted               -- 1-bit datapath strobes
//   ALUSrcB, RegDst, PCSrc        -- 2-bit mux selects
//   ALUControl                    -- ALU operation, zero-extended to ALU_W
//   state_o                       -- current state code, for debug
module mips_mc_ctrl #(
    parameter int ALU_W         = 4,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ENABLE_JR     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             Branch,
    output logic             BranchNe,
    output logic             halted,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       RegDst,
    output logic [1:0]       PCSrc,
    output logic [ALU_W-1:0] ALUControl,
    output logic [3:0]       state_o
);

    if (ALU_W < 4) begin : g_alu_w_check
        $error("mips_mc_ctrl: ALU_W must be at least 4");
    end

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WRITE = 4'd4,
        S_WB        = 4'd5,
        S_EXECUTE   = 4'd6,
        S_RT_WRITE  = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_JAL       = 4'd10,
        S_IMM_EXEC  = 4'd11,
        S_IMM_WRITE = 4'd12,
        S_JR        = 4'd13,
        S_TRAP      = 4'd15
    } state_t;

    state_t     state, state_nxt;
    logic       run_q;
    logic       mem_done;
    logic       is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic       is_imm, is_rtype, is_jr;
    logic [3:0] r_alu, i_alu, alu4;

    // Reset release is registered once, so the FSM first moves on the
    // second rising edge after rst_n goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state <= S_FETCH;
        else if (run_q) state <= state_nxt;
    end

    assign mem_done = !MEM_HANDSHAKE || mem_ready;

    assign is_lw  = opcode == 6'b100011;
    assign is_sw  = opcode == 6'b101011;
    assign is_beq = opcode == 6'b000100;
    assign is_bne = opcode == 6'b000101;
    assign is_j   = opcode == 6'b000010;
    assign is_jal = opcode == 6'b000011;
    assign is_imm = opcode == 6'b001000 || opcode == 6'b001100 ||
                    opcode == 6'b001101 || opcode == 6'b001010;
    assign is_rtype = opcode == 6'b000000 &&
                      (funct == 6'b100000 || funct == 6'b100010 ||
                       funct == 6'b100100 || funct == 6'b100101 ||
                       funct == 6'b101010);
    assign is_jr = ENABLE_JR && opcode == 6'b000000 && funct == 6'b001000;

    always_comb begin
        r_alu = 4'hF;
        case (funct)
            6'b100000: r_alu = 4'b0010;
            6'b100010: r_alu = 4'b0110;
            6'b100100: r_alu = 4'b0000;
            6'b100101: r_alu = 4'b0001;
            6'b101010: r_alu = 4'b0111;
            default:   r_alu = 4'hF;
        endcase
    end

    always_comb begin
        i_alu = 4'hF;
        case (opcode)
            6'b001000: i_alu = 4'b0010;
            6'b001100: i_alu = 4'b0000;
            6'b001101: i_alu = 4'b0001;
            6'b001010: i_alu = 4'b0111;
            default:   i_alu = 4'hF;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:     if (mem_done) state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_lw || is_sw)        state_nxt = S_MEM_ADDR;
                else if (is_beq || is_bne) state_nxt = S_BRANCH;
                else if (is_imm)           state_nxt = S_IMM_EXEC;
                else if (is_j)             state_nxt = S_JUMP;
                else if (is_jal)           state_nxt = S_JAL;
                else if (is_rtype)         state_nxt = S_EXECUTE;
                else if (is_jr)            state_nxt = S_JR;
                else                       state_nxt = S_TRAP;
            end
            S_MEM_ADDR:  state_nxt = is_lw ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_done) state_nxt = S_WB;
            S_MEM_WRITE: if (mem_done) state_nxt = S_FETCH;
            S_EXECUTE:   state_nxt = S_RT_WRITE;
            S_IMM_EXEC:  state_nxt = S_IMM_WRITE;
            S_WB, S_RT_WRITE, S_IMM_WRITE,
            S_BRANCH, S_JUMP, S_JAL, S_JR:
                         state_nxt = S_FETCH;
            S_TRAP:      state_nxt = S_TRAP;
            default:     state_nxt = S_TRAP;
        endcase
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        Branch   = 1'b0;
        BranchNe = 1'b0;
        halted   = 1'b0;
        ALUSrcB  = 2'b00;
        RegDst   = 2'b00;
        PCSrc    = 2'b00;
        alu4     = 4'hF;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                PCWrite = mem_done;
                IRWrite = mem_done;
                ALUSrcB = 2'b01;
                alu4    = 4'b0010;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu4    = 4'b0010;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu4    = r_alu;
            end
            // Operation stays on the ALU so the result is still valid here.
            S_RT_WRITE: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                alu4     = r_alu;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                alu4     = 4'b0110;
                PCSrc    = 2'b01;
                Branch   = is_beq;
                BranchNe = is_bne;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSrc    = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
            end
            S_IMM_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu4    = i_alu;
            end
            S_IMM_WRITE: begin
                RegWrite = 1'b1;
                alu4     = i_alu;
            end
            S_JR: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b11;
            end
            S_TRAP:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign ALUControl = ALU_W'(alu4);
    assign state_o    = state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: a default-parameter instance (a_*) and a
// no-handshake, no-JR instance (b_*) driven from the same stimulus.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       mem_ready = 1'b1;

    logic a_PCWrite, a_IRWrite, a_IorD, a_MemRead, a_MemWrite, a_MemtoReg;
    logic a_RegWrite, a_ALUSrcA, a_Branch, a_BranchNe, a_halted;
    logic [1:0] a_ALUSrcB, a_RegDst, a_PCSrc;
    logic [3:0] a_ALUControl, a_state;

    logic b_PCWrite, b_IRWrite, b_IorD, b_MemRead, b_MemWrite, b_MemtoReg;
    logic b_RegWrite, b_ALUSrcA, b_Branch, b_BranchNe, b_halted;
    logic [1:0] b_ALUSrcB, b_RegDst, b_PCSrc;
    logic [3:0] b_ALUControl, b_state;

    mips_mc_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready),
        .PCWrite(a_PCWrite), .IRWrite(a_IRWrite), .IorD(a_IorD),
        .MemRead(a_MemRead), .MemWrite(a_MemWrite), .MemtoReg(a_MemtoReg),
        .RegWrite(a_RegWrite), .ALUSrcA(a_ALUSrcA), .Branch(a_Branch),
        .BranchNe(a_BranchNe), .halted(a_halted), .ALUSrcB(a_ALUSrcB),
        .RegDst(a_RegDst), .PCSrc(a_PCSrc), .ALUControl(a_ALUControl),
        .state_o(a_state)
    );

    mips_mc_ctrl #(.ALU_W(4), .MEM_HANDSHAKE(1'b0), .ENABLE_JR(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready),
        .PCWrite(b_PCWrite), .IRWrite(b_IRWrite), .IorD(b_IorD),
        .MemRead(b_MemRead), .MemWrite(b_MemWrite), .MemtoReg(b_MemtoReg),
        .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA), .Branch(b_Branch),
        .BranchNe(b_BranchNe), .halted(b_halted), .ALUSrcB(b_ALUSrcB),
        .RegDst(b_RegDst), .PCSrc(b_PCSrc), .ALUControl(b_ALUControl),
        .state_o(b_state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Leaves time just after the first post-release edge; the FSM makes
    // its first move on the next rising edge.
    task automatic do_reset();
        mem_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         lat;
        logic [3:0] st2;
        logic [3:0] alu2;
        logic [1:0] pcs2;
        logic [1:0] srcb2;
        logic       srca2;
        logic       br2;
        logic       bne2;
        logic       pcw2;
        logic       rw2;
        logic [3:0] st3;
        logic [3:0] alu3;
    } vec_t;

    vec_t vt[16];

    task automatic run_vec(input vec_t v, input int idx);
        int  lat;
        bit  done;
        string tag;
        lat  = 0;
        done = 1'b0;
        tag  = $sformatf("v%0d", idx);
        opcode = v.op;
        funct  = v.fn;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 2) begin
                chk({tag, "_st2"},   a_state,      v.st2);
                chk({tag, "_alu2"},  a_ALUControl, v.alu2);
                chk({tag, "_pcsrc"}, a_PCSrc,      v.pcs2);
                chk({tag, "_srcb"},  a_ALUSrcB,    v.srcb2);
                chk({tag, "_srca"},  a_ALUSrcA,    v.srca2);
                chk({tag, "_br"},    a_Branch,     v.br2);
                chk({tag, "_bne"},   a_BranchNe,   v.bne2);
                chk({tag, "_pcw"},   a_PCWrite,    v.pcw2);
                chk({tag, "_rw2"},   a_RegWrite,   v.rw2);
            end
            if (c == 3) begin
                chk({tag, "_st3"},  a_state,      v.st3);
                chk({tag, "_alu3"}, a_ALUControl, v.alu3);
            end
            if (a_state == 4'd0) begin
                lat  = c;
                done = 1'b1;
            end
        end
        chk({tag, "_latency"}, lat, v.lat);
    endtask

    int es[10];
    int n_ir, n_rw, n_mtr;
    bit seen;

    initial begin
        vt[0]  = '{6'h00, 6'h20, 4, 4'd6,  4'h2, 2'd0, 2'd0, 1, 0, 0, 0, 0, 4'd7,  4'h2};
        vt[1]  = '{6'h00, 6'h22, 4, 4'd6,  4'h6, 2'd0, 2'd0, 1, 0, 0, 0, 0, 4'd7,  4'h6};
        vt[2]  = '{6'h00, 6'h24, 4, 4'd6,  4'h0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 4'd7,  4'h0};
        vt[3]  = '{6'h00, 6'h25, 4, 4'd6,  4'h1, 2'd0, 2'd0, 1, 0, 0, 0, 0, 4'd7,  4'h1};
        vt[4]  = '{6'h00, 6'h2a, 4, 4'd6,  4'h7, 2'd0, 2'd0, 1, 0, 0, 0, 0, 4'd7,  4'h7};
        vt[5]  = '{6'h08, 6'h00, 4, 4'd11, 4'h2, 2'd0, 2'd2, 1, 0, 0, 0, 0, 4'd12, 4'h2};
        vt[6]  = '{6'h0c, 6'h00, 4, 4'd11, 4'h0, 2'd0, 2'd2, 1, 0, 0, 0, 0, 4'd12, 4'h0};
        vt[7]  = '{6'h0d, 6'h00, 4, 4'd11, 4'h1, 2'd0, 2'd2, 1, 0, 0, 0, 0, 4'd12, 4'h1};
        vt[8]  = '{6'h0a, 6'h00, 4, 4'd11, 4'h7, 2'd0, 2'd2, 1, 0, 0, 0, 0, 4'd12, 4'h7};
        vt[9]  = '{6'h23, 6'h00, 5, 4'd2,  4'h2, 2'd0, 2'd2, 1, 0, 0, 0, 0, 4'd3,  4'hF};
        vt[10] = '{6'h2b, 6'h00, 4, 4'd2,  4'h2, 2'd0, 2'd2, 1, 0, 0, 0, 0, 4'd4,  4'hF};
        vt[11] = '{6'h04, 6'h00, 3, 4'd8,  4'h6, 2'd1, 2'd0, 1, 1, 0, 0, 0, 4'd0,  4'h2};
        vt[12] = '{6'h05, 6'h00, 3, 4'd8,  4'h6, 2'd1, 2'd0, 1, 0, 1, 0, 0, 4'd0,  4'h2};
        vt[13] = '{6'h02, 6'h00, 3, 4'd9,  4'hF, 2'd2, 2'd0, 0, 0, 0, 1, 0, 4'd0,  4'h2};
        vt[14] = '{6'h03, 6'h00, 3, 4'd10, 4'hF, 2'd2, 2'd0, 0, 0, 0, 1, 1, 4'd0,  4'h2};
        vt[15] = '{6'h00, 6'h08, 3, 4'd13, 4'hF, 2'd3, 2'd0, 0, 0, 0, 1, 0, 4'd0,  4'h2};
        es = '{0, 0, 0, 1, 2, 3, 3, 3, 5, 0};

        // Outputs while held in reset read the FETCH decodes.
        #12;
        chk("rst_state",   a_state,      4'd0);
        chk("rst_memread", a_MemRead,    1'b1);
        chk("rst_srcb",    a_ALUSrcB,    2'b01);
        chk("rst_alu",     a_ALUControl, 4'h2);
        chk("rst_pcwrite", a_PCWrite,    1'b1);
        chk("rst_irwrite", a_IRWrite,    1'b1);
        chk("rst_regwr",   a_RegWrite,   1'b0);
        chk("rst_memwr",   a_MemWrite,   1'b0);
        chk("rst_iord",    a_IorD,       1'b0);
        chk("rst_halted",  a_halted,     1'b0);
        chk("rst_b_state", b_state,      4'd0);

        for (int i = 0; i < 16; i++) begin
            do_reset();
            run_vec(vt[i], i);
        end

        // SLT write state: register destination and write enable.
        do_reset();
        opcode = 6'h00;
        funct  = 6'h2a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("slt_st7",    a_state,      4'd7);
        chk("slt_regdst", a_RegDst,     2'b01);
        chk("slt_regwr",  a_RegWrite,   1'b1);
        chk("slt_alu7",   a_ALUControl, 4'h7);

        // LW with two wait cycles in FETCH and MEM_READ.
        do_reset();
        opcode = 6'h23;
        funct  = 6'h00;
        n_ir = 0;
        n_rw = 0;
        n_mtr = 0;
        for (int c = 0; c < 10; c++) begin
            mem_ready = !(c == 0 || c == 1 || c == 5 || c == 6);
            @(negedge clk);
            chk($sformatf("lw_wait_st%0d", c), a_state, es[c]);
            if (c < 9) begin
                n_ir  += int'(a_IRWrite);
                n_rw  += int'(a_RegWrite);
                n_mtr += int'(a_MemtoReg);
            end
            if (c == 0) begin
                chk("lw_gate_pcw_a", a_PCWrite, 1'b0);
                chk("lw_gate_pcw_b", b_PCWrite, 1'b1);
            end
            if (c == 5) chk("nohs_lw_lat", b_state, 4'd0);
            @(posedge clk);
            #1;
        end
        chk("lw_ir_cnt",  n_ir,  1);
        chk("lw_rw_cnt",  n_rw,  1);
        chk("lw_mtr_cnt", n_mtr, 1);

        // Asynchronous reset while a store is in MEM_WRITE.
        do_reset();
        opcode = 6'h2b;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (a_state == 4'd4) seen = 1'b1;
        end
        chk("sw_reach",  a_state,    4'd4);
        chk("sw_memwr",  a_MemWrite, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_memwr", a_MemWrite, 1'b0);
        chk("arst_state", a_state,    4'd0);
        chk("arst_iord",  a_IorD,     1'b0);

        // Release synchronisation: first move on the second rising edge.
        opcode = 6'h23;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("sync_rel", a_state, 4'd0);
        @(posedge clk);
        @(negedge clk);
        chk("sync_hold", a_state, 4'd0);
        @(posedge clk);
        @(negedge clk);
        chk("sync_first", a_state, 4'd1);

        // JR traps on the instance built without JR support.
        do_reset();
        opcode = 6'h00;
        funct  = 6'h08;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("nojr_st_c%0d", c),  b_state,  4'd15);
                chk($sformatf("nojr_hlt_c%0d", c), b_halted, 1'b1);
            end
        end

        // Illegal opcode traps; no architectural writes afterwards.
        do_reset();
        opcode = 6'h3f;
        funct  = 6'h00;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("trap_st_c%0d", c), a_state, 4'd15);
                chk($sformatf("trap_wr_c%0d", c),
                    {a_RegWrite, a_MemWrite, a_PCWrite}, 3'b000);
            end
        end
        do_reset();
        chk("trap_clr_st",  a_state,  4'd0);
        chk("trap_clr_hlt", a_halted, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
